// File: rtl/pwr_seq_ctrl_if.sv
// Software-control / board-pin bundle between the register file, the pins and the power sequencer.
interface pwr_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       fault_clr;
    logic [5:0] load_en_req;
    logic       pg_3v3;
    logic       pg_2v5;
    logic [3:0] alert_n;
    logic       en_3v3;
    logic       en_2v5;
    logic [5:0] load_en;
    logic [2:0] state;
    logic [3:0] fault_code;
    logic [3:0] alert_seen;
    logic       seq_done;

    modport master (
        output start, stop, fault_clr, load_en_req, pg_3v3, pg_2v5, alert_n,
        input  en_3v3, en_2v5, load_en, state, fault_code, alert_seen, seq_done
    );

    modport slave (
        input  start, stop, fault_clr, load_en_req, pg_3v3, pg_2v5, alert_n,
        output en_3v3, en_2v5, load_en, state, fault_code, alert_seen, seq_done
    );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Power sequencer: ramps the 3V3/2V5 rails, steps six load enables on, and shuts down
// in order or trips to FAULT on power-good loss, PG timeout or a debounced LTC alert.
module pwr_seq_ctrl #(
    parameter int unsigned PG_TIMEOUT_CYC = 10_000_000,
    parameter int unsigned DEBOUNCE_CYC   = 1000,
    parameter int unsigned STEP_CYC       = 100_000
) (
    input logic           clk_axi,
    input logic           rst,
    pwr_seq_ctrl_if.slave bus
);
    localparam int unsigned NIN      = 6;
    localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int unsigned WAIT_MAX = (PG_TIMEOUT_CYC > STEP_CYC) ? PG_TIMEOUT_CYC : STEP_CYC;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
    // Pin vector {alert_n[3:0], pg_2v5, pg_3v3}; idle value is "alerts inactive, PG not good".
    localparam logic [NIN-1:0] IN_RST = 6'b111100;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_RAMP     = 3'd1,
        S_LOADS    = 3'd2,
        S_ON       = 3'd3,
        S_SHUTDOWN = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    logic [NIN-1:0]  raw, sync1, sync2, deb;
    logic [DB_W-1:0] db_cnt [NIN];
    logic            start_q, stop_q, clr_q;
    logic            start_edge, stop_edge, clr_edge;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            rails_q, rails_d;
    logic [5:0]      load_en_q, load_en_d;
    logic [3:0]      fault_code_q, fault_code_d;
    logic [3:0]      alert_seen_q, alert_seen_d;
    logic            seq_done_q, seq_done_d;

    logic            pg3, pg2;
    logic [3:0]      alert_act;
    logic [3:0]      alert_code;
    logic [3:0]      fault_d;

    assign raw       = {bus.alert_n, bus.pg_2v5, bus.pg_3v3};
    assign pg3       = deb[0];
    assign pg2       = deb[1];
    assign alert_act = ~deb[5:2];

    // Two-flop synchronizer followed by a per-bit consecutive-sample debouncer.
    always_ff @(posedge clk_axi) begin
        if (rst) begin
            sync1 <= IN_RST;
            sync2 <= IN_RST;
            deb   <= IN_RST;
            for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Registered rising-edge pulses for the software control levels.
    always_ff @(posedge clk_axi) begin
        if (rst) begin
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            clr_q      <= 1'b0;
            start_edge <= 1'b0;
            stop_edge  <= 1'b0;
            clr_edge   <= 1'b0;
        end else begin
            start_q    <= bus.start;
            stop_q     <= bus.stop;
            clr_q      <= bus.fault_clr;
            start_edge <= bus.start & ~start_q;
            stop_edge  <= bus.stop & ~stop_q;
            clr_edge   <= bus.fault_clr & ~clr_q;
        end
    end

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            idx_q        <= '0;
            rails_q      <= 1'b0;
            load_en_q    <= '0;
            fault_code_q <= '0;
            alert_seen_q <= '0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rails_q      <= rails_d;
            load_en_q    <= load_en_d;
            fault_code_q <= fault_code_d;
            alert_seen_q <= alert_seen_d;
            seq_done_q   <= seq_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        load_en_d    = load_en_q;
        fault_code_d = fault_code_q;
        alert_seen_d = (clr_edge ? 4'd0 : alert_seen_q) | alert_act;
        fault_d      = 4'd0;
        alert_code   = 4'd0;

        // Lowest-numbered active alert gives the lowest fault code.
        for (int k = 3; k >= 0; k--) begin
            if (alert_act[k]) alert_code = 4'(5 + k);
        end

        case (state_q)
            S_OFF: begin
                if (start_edge) state_d = S_RAMP;
            end
            S_RAMP: begin
                if ((cnt_q == CNT_W'(PG_TIMEOUT_CYC - 1)) && !(pg3 && pg2))
                    fault_d = pg3 ? 4'd2 : 4'd1;
                else
                    fault_d = alert_code;
                if (stop_edge)         state_d = S_SHUTDOWN;
                else if (pg3 && pg2)   state_d = S_LOADS;
            end
            S_LOADS: begin
                fault_d = !pg3 ? 4'd3 : (!pg2 ? 4'd4 : alert_code);
                if (stop_edge) begin
                    state_d = S_SHUTDOWN;
                end else if (idx_q == 3'd6) begin
                    state_d = S_ON;
                end else if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
                    for (int i = 0; i < 6; i++) begin
                        if (idx_q == 3'(i)) load_en_d[i] = bus.load_en_req[i];
                    end
                    idx_d = idx_q + 3'd1;
                    cnt_d = '0;
                end
            end
            S_ON: begin
                fault_d   = !pg3 ? 4'd3 : (!pg2 ? 4'd4 : alert_code);
                load_en_d = bus.load_en_req;
                if (stop_edge) state_d = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                fault_d = alert_code;
                if (cnt_q == CNT_W'(STEP_CYC - 1)) state_d = S_OFF;
            end
            S_FAULT: begin
                if (clr_edge && !start_q) begin
                    state_d      = S_OFF;
                    fault_code_d = 4'd0;
                end
            end
            default: state_d = S_OFF;
        endcase

        // A fault overrides stop and normal progress in the same cycle.
        if (fault_d != 4'd0) begin
            state_d      = S_FAULT;
            fault_code_d = fault_d;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            idx_d = '0;
        end

        rails_d    = (state_d == S_RAMP) || (state_d == S_LOADS) ||
                     (state_d == S_ON)   || (state_d == S_SHUTDOWN);
        if ((state_d == S_OFF) || (state_d == S_SHUTDOWN) || (state_d == S_FAULT))
            load_en_d = '0;
        seq_done_d = (state_d == S_ON);
    end

    assign bus.en_3v3     = rails_q;
    assign bus.en_2v5     = rails_q;
    assign bus.load_en    = load_en_q;
    assign bus.state      = state_q;
    assign bus.fault_code = fault_code_q;
    assign bus.alert_seen = alert_seen_q;
    assign bus.seq_done   = seq_done_q;
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: vector table for the nominal ramp, directed corner
// sequences, and randomized runs checked against timing derived from the sequencing rules.
module tb_pwr_seq_ctrl;
    localparam int unsigned PG_TO = 200;
    localparam int unsigned DB    = 4;
    localparam int unsigned STEP  = 10;

    localparam logic [2:0] ST_OFF = 3'd0, ST_RAMP = 3'd1, ST_LOADS = 3'd2,
                           ST_ON  = 3'd3, ST_SHUT = 3'd4, ST_FAULT = 3'd5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pwr_seq_ctrl_if bus();

    pwr_seq_ctrl #(
        .PG_TIMEOUT_CYC(PG_TO),
        .DEBOUNCE_CYC  (DB),
        .STEP_CYC      (STEP)
    ) dut (
        .clk_axi(clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        logic [5:0]  req;
        logic [2:0]  st;
        logic [5:0]  le;
        logic        sd;
        logic        rails;
    } vec_t;

    vec_t tbl [15];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (bus.state == st) break;
            tick(1);
        end
        check(name, 32'(bus.state), 32'(st));
    endtask

    task automatic power_up(input logic [5:0] req);
        bus.load_en_req = req;
        bus.pg_3v3 = 1'b1;
        bus.pg_2v5 = 1'b1;
        tick(8);
        bus.start = 1'b1;
        wait_state(ST_RAMP, 4, "pu_ramp");
        bus.start = 1'b0;
        wait_state(ST_ON, 90, "pu_on");
    endtask

    task automatic clear_fault();
        bus.fault_clr = 1'b1;
        wait_state(ST_OFF, 4, "clr_to_off");
        bus.fault_clr = 1'b0;
        tick(1);
    endtask

    // Expected load enables after s completed steps: the first s requested bits.
    function automatic logic [5:0] steps_model(input logic [5:0] req, input int s);
        int m;
        m = (1 << s) - 1;
        return req & 6'(m);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] r;
        int d, k, l;
        logic p3, p2;

        // LOADS offsets relative to LOADS entry, then ON with one-cycle follow of the request.
        tbl[0]  = '{0,  6'b101101, ST_LOADS, 6'b000000, 1'b0, 1'b1};
        tbl[1]  = '{9,  6'b101101, ST_LOADS, 6'b000000, 1'b0, 1'b1};
        tbl[2]  = '{10, 6'b101101, ST_LOADS, 6'b000001, 1'b0, 1'b1};
        tbl[3]  = '{29, 6'b101101, ST_LOADS, 6'b000001, 1'b0, 1'b1};
        tbl[4]  = '{30, 6'b101101, ST_LOADS, 6'b000101, 1'b0, 1'b1};
        tbl[5]  = '{39, 6'b101101, ST_LOADS, 6'b000101, 1'b0, 1'b1};
        tbl[6]  = '{40, 6'b101101, ST_LOADS, 6'b001101, 1'b0, 1'b1};
        tbl[7]  = '{50, 6'b101101, ST_LOADS, 6'b001101, 1'b0, 1'b1};
        tbl[8]  = '{59, 6'b101101, ST_LOADS, 6'b001101, 1'b0, 1'b1};
        tbl[9]  = '{60, 6'b101101, ST_LOADS, 6'b101101, 1'b0, 1'b1};
        tbl[10] = '{61, 6'b010010, ST_ON,    6'b101101, 1'b1, 1'b1};
        tbl[11] = '{62, 6'b111111, ST_ON,    6'b010010, 1'b1, 1'b1};
        tbl[12] = '{63, 6'b000000, ST_ON,    6'b111111, 1'b1, 1'b1};
        tbl[13] = '{64, 6'b111111, ST_ON,    6'b000000, 1'b1, 1'b1};
        tbl[14] = '{65, 6'b111111, ST_ON,    6'b111111, 1'b1, 1'b1};

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.fault_clr = 1'b0;
        bus.load_en_req = '0; bus.pg_3v3 = 1'b0; bus.pg_2v5 = 1'b0; bus.alert_n = 4'hF;
        tick(3);
        check("rst_state", 32'(bus.state), 32'(ST_OFF));
        check("rst_rails", 32'({bus.en_3v3, bus.en_2v5}), 32'd0);
        check("rst_load", 32'(bus.load_en), 32'd0);
        check("rst_code", 32'(bus.fault_code), 32'd0);
        check("rst_seen", 32'(bus.alert_seen), 32'd0);
        check("rst_done", 32'(bus.seq_done), 32'd0);
        rst = 1'b0;
        tick(2);

        // Nominal ramp: start edge to RAMP in two cycles, PG after 20 cycles.
        bus.load_en_req = 6'b101101;
        bus.start = 1'b1;
        tick(1);
        check("nom_n1_off", 32'(bus.state), 32'(ST_OFF));
        tick(1);
        check("nom_ramp", 32'(bus.state), 32'(ST_RAMP));
        check("nom_ramp_rails", 32'({bus.en_3v3, bus.en_2v5}), 32'd3);
        bus.start = 1'b0;
        tick(18);
        bus.pg_3v3 = 1'b1; bus.pg_2v5 = 1'b1;
        tick(2 + DB);
        check("nom_pg_still_ramp", 32'(bus.state), 32'(ST_RAMP));
        tick(1);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) tick(tbl[i].at - tbl[i-1].at);
            check($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_load", i), 32'(bus.load_en), 32'(tbl[i].le));
            check($sformatf("tbl%0d_done", i), 32'(bus.seq_done), 32'(tbl[i].sd));
            check($sformatf("tbl%0d_rails", i), 32'({bus.en_3v3, bus.en_2v5}),
                  32'({tbl[i].rails, tbl[i].rails}));
            bus.load_en_req = tbl[i].req;
        end

        // Alert glitch shorter than the debounce window is ignored; a long one trips FAULT.
        bus.alert_n = 4'b1011;
        tick(3);
        bus.alert_n = 4'hF;
        tick(10);
        check("glitch_state", 32'(bus.state), 32'(ST_ON));
        check("glitch_seen", 32'(bus.alert_seen), 32'd0);
        bus.alert_n = 4'b1011;
        tick(2 + DB);
        check("alert_pre_state", 32'(bus.state), 32'(ST_ON));
        tick(1);
        check("alert_state", 32'(bus.state), 32'(ST_FAULT));
        check("alert_code", 32'(bus.fault_code), 32'd7);
        check("alert_seen", 32'(bus.alert_seen), 32'b0100);
        check("alert_load", 32'(bus.load_en), 32'd0);
        check("alert_rails", 32'({bus.en_3v3, bus.en_2v5}), 32'd0);
        check("alert_done", 32'(bus.seq_done), 32'd0);
        tick(2);
        bus.alert_n = 4'hF;
        tick(8);
        check("seen_sticky", 32'(bus.alert_seen), 32'b0100);
        clear_fault();
        check("clr_code", 32'(bus.fault_code), 32'd0);
        check("clr_seen", 32'(bus.alert_seen), 32'd0);

        // PG timeout with 2V5 missing; fault_clr ignored while start is high.
        bus.pg_2v5 = 1'b0;
        tick(8);
        bus.start = 1'b1;
        tick(2);
        check("to_ramp", 32'(bus.state), 32'(ST_RAMP));
        tick(PG_TO - 1);
        check("to_pre", 32'(bus.state), 32'(ST_RAMP));
        tick(1);
        check("to_state", 32'(bus.state), 32'(ST_FAULT));
        check("to_code", 32'(bus.fault_code), 32'd2);
        check("to_rails", 32'({bus.en_3v3, bus.en_2v5}), 32'd0);
        bus.fault_clr = 1'b1;
        tick(3);
        check("to_clr_ignored", 32'(bus.state), 32'(ST_FAULT));
        check("to_clr_code", 32'(bus.fault_code), 32'd2);
        bus.fault_clr = 1'b0; bus.start = 1'b0;
        tick(2);
        bus.fault_clr = 1'b1;
        tick(2);
        check("to_clr_off", 32'(bus.state), 32'(ST_OFF));
        check("to_clr_code0", 32'(bus.fault_code), 32'd0);
        bus.fault_clr = 1'b0;

        // Stop in OFF is ignored.
        bus.stop = 1'b1;
        tick(3);
        check("stop_off", 32'(bus.state), 32'(ST_OFF));
        bus.stop = 1'b0;
        tick(1);

        // Stop in ON: loads drop on SHUTDOWN entry, rails STEP cycles later.
        power_up(6'b111111);
        tick(1);
        check("pu_load", 32'(bus.load_en), 32'h3F);
        bus.stop = 1'b1;
        tick(1);
        check("stop_n1", 32'(bus.state), 32'(ST_ON));
        tick(1);
        check("stop_shut", 32'(bus.state), 32'(ST_SHUT));
        check("stop_load", 32'(bus.load_en), 32'd0);
        check("stop_rails_on", 32'({bus.en_3v3, bus.en_2v5}), 32'd3);
        tick(STEP - 1);
        check("stop_pre", 32'({bus.en_3v3, bus.en_2v5}), 32'd3);
        tick(1);
        check("stop_off_state", 32'(bus.state), 32'(ST_OFF));
        check("stop_rails_off", 32'({bus.en_3v3, bus.en_2v5}), 32'd0);
        bus.stop = 1'b0;

        // Stop and start edges together in ON: stop wins.
        power_up(6'b000011);
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(2);
        check("ss_state", 32'(bus.state), 32'(ST_SHUT));
        bus.start = 1'b0; bus.stop = 1'b0;
        wait_state(ST_OFF, 15, "ss_off");

        // Simultaneous PG 3V3 loss and alert 0 in LOADS: PG code wins.
        bus.load_en_req = 6'b101101;
        bus.start = 1'b1;
        wait_state(ST_LOADS, 20, "sim_loads");
        bus.start = 1'b0;
        tick(5);
        bus.pg_3v3 = 1'b0; bus.alert_n = 4'b1110;
        tick(2 + DB);
        check("sim_pre", 32'(bus.state), 32'(ST_LOADS));
        tick(1);
        check("sim_state", 32'(bus.state), 32'(ST_FAULT));
        check("sim_code", 32'(bus.fault_code), 32'd3);
        check("sim_seen", 32'(bus.alert_seen), 32'b0001);
        bus.pg_3v3 = 1'b1; bus.alert_n = 4'hF;
        tick(8);
        clear_fault();

        // Reset mid-LOADS at step 3, then a full restart from step 0.
        bus.start = 1'b1;
        wait_state(ST_LOADS, 20, "rl_loads");
        bus.start = 1'b0;
        tick(35);
        check("rl_pre_load", 32'(bus.load_en), 32'b000101);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rl_state", 32'(bus.state), 32'(ST_OFF));
        check("rl_load", 32'(bus.load_en), 32'd0);
        check("rl_rails", 32'({bus.en_3v3, bus.en_2v5}), 32'd0);
        check("rl_code", 32'(bus.fault_code), 32'd0);
        bus.start = 1'b1;
        wait_state(ST_RAMP, 4, "rl_ramp");
        bus.start = 1'b0;
        wait_state(ST_LOADS, 20, "rl_loads2");
        tick(STEP);
        check("rl_step0", 32'(bus.load_en), 32'b000001);
        tick(2 * STEP);
        check("rl_step2", 32'(bus.load_en), 32'b000101);
        wait_state(ST_ON, 50, "rl_on");
        bus.stop = 1'b1;
        wait_state(ST_OFF, 20, "rl_off");
        bus.stop = 1'b0;

        // Randomized ramps, step patterns, PG timeouts and alert pulses.
        for (int it = 0; it < 10; it++) begin
            r  = 6'($urandom);
            d  = int'($urandom_range(1, 150));
            p3 = ($urandom_range(0, 3) != 0);
            p2 = ($urandom_range(0, 3) != 0);
            bus.load_en_req = r;
            bus.pg_3v3 = 1'b0; bus.pg_2v5 = 1'b0; bus.alert_n = 4'hF;
            tick(8);
            bus.start = 1'b1;
            tick(2);
            check("rnd_ramp", 32'(bus.state), 32'(ST_RAMP));
            bus.start = 1'b0;
            tick(d);
            bus.pg_3v3 = p3; bus.pg_2v5 = p2;
            if (p3 && p2) begin
                tick(2 + DB + 1);
                check("rnd_loads", 32'(bus.state), 32'(ST_LOADS));
                for (int s = 1; s <= 6; s++) begin
                    tick(STEP);
                    check($sformatf("rnd%0d_step%0d", it, s), 32'(bus.load_en),
                          32'(steps_model(r, s)));
                end
                tick(1);
                check("rnd_on", 32'(bus.state), 32'(ST_ON));
                check("rnd_done", 32'(bus.seq_done), 32'd1);
                k = int'($urandom_range(0, 3));
                l = int'($urandom_range(1, 8));
                bus.alert_n[k] = 1'b0;
                for (int c = 1; c <= 2 + DB + 1; c++) begin
                    tick(1);
                    if (c == l) bus.alert_n = 4'hF;
                end
                bus.alert_n = 4'hF;
                if (l >= int'(DB)) begin
                    check("rnd_afault", 32'(bus.state), 32'(ST_FAULT));
                    check("rnd_acode", 32'(bus.fault_code), 32'(5 + k));
                    check("rnd_aseen", 32'(bus.alert_seen), 32'(1 << k));
                    tick(8);
                    clear_fault();
                end else begin
                    tick(4);
                    check("rnd_noalert", 32'(bus.state), 32'(ST_ON));
                    check("rnd_noseen", 32'(bus.alert_seen), 32'd0);
                    bus.stop = 1'b1;
                    wait_state(ST_OFF, 20, "rnd_stop_off");
                    bus.stop = 1'b0;
                end
            end else begin
                tick(PG_TO - d - 1);
                check("rnd_to_pre", 32'(bus.state), 32'(ST_RAMP));
                tick(1);
                check("rnd_to_state", 32'(bus.state), 32'(ST_FAULT));
                check("rnd_to_code", 32'(bus.fault_code), p3 ? 32'd2 : 32'd1);
                clear_fault();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
